trigger_request_gen: RTL and testbench
======================================

TRIGGER_REQUEST_GEN -- requirements
Module: trigger_request_gen

Interface
REQ-001 Parameter CNT_W, 8, width of request index, request total and trigger counter.
REQ-002 Parameter PERIOD_W, 16, width of the inter-request gap value.
REQ-003 Parameter TIMEOUT, 1024, cycles to wait for ack before declaring timeout (>=2).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  level; 1 = run request cycles continuously, 0 = stop after current request.
REQ-007 period  in  PERIOD_W  idle cycles between ack and next request; sampled at cycle start.
REQ-008 n_req  in  CNT_W  requests per cycle; sampled at cycle start.
REQ-009 ack  in  1  one-cycle pulse from the consumer: current request serviced.
REQ-010 clr_err  in  1  clears timeout_err.
REQ-011 request_trig  out  1  registered one-cycle trigger pulse to the counting/consumer side.
REQ-012 req_index  out  CNT_W  index of the outstanding or next request within the cycle.
REQ-013 trig_count  out  CNT_W  total request_trig pulses since reset, wraps.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 cycle_done  out  1  one-cycle pulse after the last request of a cycle is acked or timed out.
REQ-016 timeout_err  out  1  sticky flag, set on any ack timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_ACK, GAP, DONE.
REQ-018 IDLE: enable=1 and n_req!=0 -> latch period, n_req; req_index=0; next REQ. n_req=0 -> stay IDLE.
REQ-019 REQ: request_trig=1 for exactly this one cycle, trig_count+1 (mod 2^CNT_W), timeout counter cleared; next WAIT_ACK.
REQ-020 WAIT_ACK: ack=1 -> if req_index==n_req_latched-1 next DONE, else req_index+1, next GAP.
REQ-021 WAIT_ACK: TIMEOUT cycles elapsed without ack -> timeout_err=1, then same transition as ack.
REQ-022 GAP: wait max(period_latched,1) cycles then REQ; enable=0 during GAP -> IDLE immediately, req_index=0.
REQ-023 DONE: cycle_done=1 for one cycle; req_index=0; enable=1 -> re-latch period/n_req, next GAP (n_req=0 -> IDLE); enable=0 -> IDLE.
REQ-024 enable=0 in REQ or WAIT_ACK SHALL NOT abort; the outstanding request completes (ack/timeout) then IDLE, no cycle_done.
REQ-025 ack outside WAIT_ACK (including the REQ cycle) SHALL be ignored.
REQ-026 Latency: request_trig SHALL rise exactly period+1 cycles after the ack-cycle edge (GAP length plus REQ register).
REQ-027 ack and timeout in the same cycle SHALL count as ack; timeout_err not set.
REQ-028 clr_err and a new timeout in the same cycle: set wins.
REQ-029 period/n_req changes mid-cycle SHALL NOT affect the running cycle.

Reset
REQ-030 rst=0 at a clock edge -> state IDLE, request_trig=0, req_index=0, trig_count=0, busy=0, cycle_done=0, timeout_err=0, all internal counters 0.
REQ-031 Reset mid-cycle SHALL abandon the outstanding request without further pulses.

Structure
REQ-032 FSM state encoding, CNT_W/PERIOD_W defaults and TIMEOUT default SHALL live in the shared mopshub package.
REQ-033 The gap/timeout down-counter SHALL be one sub-module, gap_timer (load, count, expired), reused for both GAP and WAIT_ACK.
REQ-034 All outputs SHALL be registered; no combinational path from ack to request_trig.

Verification
REQ-035 enable=1, n_req=3, period=4, ack 2 cycles after each request_trig -> 3 pulses, gaps 5 cycles ack-to-pulse, cycle_done once, trig_count=3.
REQ-036 n_req=2, no ack, TIMEOUT=16 -> timeout_err=1 after 16 cycles, second pulse follows, cycle_done; clr_err clears flag.
REQ-037 enable dropped in WAIT_ACK of request 1 of 4 -> no further pulse after ack, busy=0, no cycle_done.
REQ-038 trig_count from 254, two requests -> 255 then 0.
REQ-039 ack asserted during REQ cycle only -> ignored, request times out; n_req=0 with enable=1 -> no pulse, busy=0.
REQ-040 rst=0 during GAP -> all outputs at reset values next cycle; no pulse until re-enabled.

Source files
------------

// File: rtl/mopshub_pkg.sv
// Shared mopshub definitions for the trigger request generator.
// Holds the FSM state encoding, the default widths and timeout, and a
// small constant helper used to size internal counters.
package mopshub_pkg;

   // Trigger request FSM states; exported on dbg_state for checkers.
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_GAP      = 3'd3,
      ST_DONE     = 3'd4
   } trg_state_e;

   localparam int TRG_CNT_W    = 8;     // request index / total / trigger counter width
   localparam int TRG_PERIOD_W = 16;    // inter-request gap width
   localparam int TRG_TIMEOUT  = 1024;  // ack wait budget in cycles (>= 2)

   function automatic int trg_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/gap_timer.sv
// gap_timer: loadable down-counter shared by the GAP and WAIT_ACK phases.
// Ports:
//   clk, rst     clock, synchronous active-low reset
//   load         load load_val this cycle (has priority over count)
//   load_val     value to load
//   count        decrement this cycle (saturates at zero)
//   expired      high while the counter holds 1, i.e. in the last cycle of
//                a window of load_val counting cycles
module gap_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         count,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   // Loading N and counting gives exactly N cycles with expired on the Nth.
   assign expired = (cnt == W'(1));

endmodule

// File: rtl/trigger_request_gen.sv
// trigger_request_gen: issues cycles of n_req trigger requests, each one
// waiting for a consumer ack (or timing out) and separated by a
// programmable idle gap.
//
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   enable        level; 1 runs request cycles back to back, 0 stops after
//                 the outstanding request
//   period        idle cycles between ack and next request (0 acts as 1)
//   n_req         requests per cycle (0 = do not start)
//   ack           one-cycle pulse: current request serviced
//   clr_err       clears timeout_err (a simultaneous new timeout wins)
//   request_trig  one-cycle trigger pulse
//   req_index     index of the outstanding or next request within the cycle
//   trig_count    request_trig pulses since reset, wrapping
//   busy          high in every state except IDLE
//   cycle_done    one-cycle pulse after the last request of a cycle
//   timeout_err   sticky ack-timeout flag
//   dbg_state     current FSM state
//
// Handshake: request_trig is a pulse, not a held valid. An ack counts only
// while a request is outstanding (the cycles after request_trig rises until
// the request completes); acks at any other time, including the cycle
// request_trig is being registered, are dropped. An ack in the same cycle
// as the timeout counts as a normal ack.
module trigger_request_gen
   import mopshub_pkg::*;
#(
   parameter int CNT_W    = TRG_CNT_W,
   parameter int PERIOD_W = TRG_PERIOD_W,
   parameter int TIMEOUT  = TRG_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [PERIOD_W-1:0] period,
   input  logic [CNT_W-1:0]    n_req,
   input  logic                ack,
   input  logic                clr_err,
   output logic                request_trig,
   output logic [CNT_W-1:0]    req_index,
   output logic [CNT_W-1:0]    trig_count,
   output logic                busy,
   output logic                cycle_done,
   output logic                timeout_err,
   output trg_state_e          dbg_state
);

   // One counter serves both the gap and the ack timeout, so it must hold
   // whichever is larger.
   localparam int TMR_W = trg_max(PERIOD_W, $clog2(TIMEOUT + 1));

   trg_state_e          state;
   logic [PERIOD_W-1:0] period_q;
   logic [CNT_W-1:0]    n_req_q;
   logic                stop_pend;   // enable was seen low while a request was in flight

   logic                tmr_load;
   logic                tmr_count;
   logic [TMR_W-1:0]    tmr_val;
   logic                tmr_expired;

   logic                start_ok;
   logic                req_end;     // outstanding request completes this cycle
   logic                timeout_set;
   logic                last_req;

   function automatic logic [TMR_W-1:0] gap_len(input logic [PERIOD_W-1:0] p);
      return (p == '0) ? TMR_W'(1) : TMR_W'(p);
   endfunction

   assign start_ok    = enable && (n_req != '0);
   assign req_end     = (state == ST_WAIT_ACK) && (ack || tmr_expired);
   assign timeout_set = (state == ST_WAIT_ACK) && tmr_expired && !ack;
   assign last_req    = (req_index == (n_req_q - CNT_W'(1)));
   assign dbg_state   = state;

   // Timer control. The gap value is loaded on the way out of WAIT_ACK and
   // DONE unconditionally; if the FSM goes elsewhere the load is harmless
   // because REQ reloads the timeout before the timer is used again.
   always_comb begin
      tmr_load  = 1'b0;
      tmr_count = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_REQ: begin
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(TIMEOUT);
         end
         ST_WAIT_ACK: begin
            if (req_end) begin
               tmr_load = 1'b1;
               tmr_val  = gap_len(period_q);
            end else begin
               tmr_count = 1'b1;
            end
         end
         ST_GAP: begin
            tmr_count = 1'b1;
         end
         ST_DONE: begin
            tmr_load = 1'b1;
            tmr_val  = gap_len(period);
         end
         default: begin
         end
      endcase
   end

   gap_timer #(
      .W (TMR_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .count    (tmr_count),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= ST_IDLE;
         period_q     <= '0;
         n_req_q      <= '0;
         stop_pend    <= 1'b0;
         request_trig <= 1'b0;
         req_index    <= '0;
         trig_count   <= '0;
         busy         <= 1'b0;
         cycle_done   <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         request_trig <= 1'b0;
         cycle_done   <= 1'b0;

         if (timeout_set) begin
            timeout_err <= 1'b1;
         end else if (clr_err) begin
            timeout_err <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (start_ok) begin
                  period_q  <= period;
                  n_req_q   <= n_req;
                  req_index <= '0;
                  stop_pend <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_REQ;
               end
            end

            ST_REQ: begin
               request_trig <= 1'b1;
               trig_count   <= trig_count + CNT_W'(1);
               if (!enable) begin
                  stop_pend <= 1'b1;
               end
               state <= ST_WAIT_ACK;
            end

            ST_WAIT_ACK: begin
               if (!enable) begin
                  stop_pend <= 1'b1;
               end
               if (req_end) begin
                  if (stop_pend || !enable) begin
                     // Stop requested: finish quietly, no cycle_done.
                     req_index <= '0;
                     busy      <= 1'b0;
                     state     <= ST_IDLE;
                  end else if (last_req) begin
                     req_index  <= '0;
                     cycle_done <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     req_index <= req_index + CNT_W'(1);
                     state     <= ST_GAP;
                  end
               end
            end

            ST_GAP: begin
               if (!enable) begin
                  req_index <= '0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end else if (tmr_expired) begin
                  state <= ST_REQ;
               end
            end

            ST_DONE: begin
               if (start_ok) begin
                  // Back-to-back cycle: new settings, first request after a gap.
                  period_q  <= period;
                  n_req_q   <= n_req;
                  stop_pend <= 1'b0;
                  state     <= ST_GAP;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               req_index <= '0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trigger_request_gen.sv
// Testbench for trigger_request_gen: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// timeline model of the request schedule.
module tb_trigger_request_gen;
   import mopshub_pkg::*;

   localparam int CW = 8;
   localparam int PW = 16;
   localparam int TO = 16;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          enable = 1'b0;
   logic [PW-1:0] period = '0;
   logic [CW-1:0] n_req = '0;
   logic          ack = 1'b0;
   logic          clr_err = 1'b0;
   logic          request_trig;
   logic [CW-1:0] req_index;
   logic [CW-1:0] trig_count;
   logic          busy;
   logic          cycle_done;
   logic          timeout_err;
   trg_state_e    dbg_state;

   always #5 clk = ~clk;

   trigger_request_gen #(
      .CNT_W    (CW),
      .PERIOD_W (PW),
      .TIMEOUT  (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .period       (period),
      .n_req        (n_req),
      .ack          (ack),
      .clr_err      (clr_err),
      .request_trig (request_trig),
      .req_index    (req_index),
      .trig_count   (trig_count),
      .busy         (busy),
      .cycle_done   (cycle_done),
      .timeout_err  (timeout_err),
      .dbg_state    (dbg_state)
   );

   // ---------------- scoreboard bookkeeping ----------------
   int n_cmp  = 0;
   int n_fail = 0;
   logic [CW-1:0] exp_q[$];   // expected trig_count at each predicted pulse

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Timeline view: a scheduled pulse counts down in edges, an outstanding
   // request counts edges waited, a finished cycle leaves one decision edge.
   int            m_cyc = 0;       // posedge number
   bit            m_busy = 0;
   int            m_idx = 0, m_tot = 0, m_per = 0;
   int            m_pulse_in = 0;  // edges until the next pulse (0 = none)
   int            m_wait_k = 0;    // edges waited on the outstanding request
   bit            m_stop = 0, m_decide = 0, m_err = 0, m_set_err = 0;
   logic [CW-1:0] m_count = '0;
   bit            e_trig = 0, e_done = 0;

   function automatic int gap_of(input int p);
      return (p == 0) ? 1 : p;
   endfunction

   task automatic m_idle();
      m_busy = 0; m_idx = 0; m_pulse_in = 0; m_wait_k = 0; m_decide = 0;
   endtask

   always @(posedge clk) begin
      m_cyc++;
      e_trig = 0;
      e_done = 0;
      m_set_err = 0;
      if (!rst) begin
         m_idle();
         m_stop = 0; m_err = 0; m_count = '0; m_tot = 0; m_per = 0;
         exp_q.delete();
      end else begin
         if (m_wait_k > 0) begin
            if (!enable) m_stop = 1;
            if (ack || m_wait_k == TO) begin
               m_set_err = !ack;
               m_wait_k = 0;
               if (m_stop) m_idle();
               else if (m_idx == m_tot - 1) begin
                  e_done = 1; m_idx = 0; m_decide = 1;
               end else begin
                  m_idx++; m_pulse_in = gap_of(m_per) + 1;
               end
            end else begin
               m_wait_k++;
            end
         end else if (m_decide) begin
            m_decide = 0;
            if (enable && n_req != 0) begin
               m_tot = int'(n_req); m_per = int'(period);
               m_pulse_in = gap_of(m_per) + 1; m_stop = 0;
            end else begin
               m_idle();
            end
         end else if (m_pulse_in > 0) begin
            if (m_pulse_in >= 2 && !enable) begin
               m_idle();
            end else begin
               m_pulse_in--;
               if (m_pulse_in == 0) begin
                  e_trig = 1;
                  m_count = m_count + 8'd1;
                  exp_q.push_back(m_count);
                  m_wait_k = 1;
                  if (!enable) m_stop = 1;
               end
            end
         end else if (enable && n_req != 0) begin
            m_busy = 1; m_tot = int'(n_req); m_per = int'(period);
            m_idx = 0; m_stop = 0; m_pulse_in = 1;
         end
         if (m_set_err) m_err = 1;
         else if (clr_err) m_err = 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check("request_trig", request_trig, e_trig);
         check("req_index", req_index, m_idx);
         check("trig_count", trig_count, m_count);
         check("busy", busy, m_busy);
         check("cycle_done", cycle_done, e_done);
         check("timeout_err", timeout_err, m_err);
      end
   end

   // ---------------- monitor / stats ----------------
   int pulses = 0, done_cnt = 0, err_edge = -1;
   int trig_q[$];
   int cnt_q[$];
   int ack_q[$];
   bit prev_err = 0;

   always @(negedge clk) begin
      if (request_trig === 1'b1) begin
         pulses++;
         trig_q.push_back(m_cyc);
         cnt_q.push_back(int'(trig_count));
         if (exp_q.size() == 0) check("pulse_unexpected", 1, 0);
         else check("pulse_trig_count", trig_count, exp_q.pop_front());
      end
      if (cycle_done === 1'b1) done_cnt++;
      if (timeout_err === 1'b1 && !prev_err && err_edge < 0) err_edge = m_cyc;
      prev_err = (timeout_err === 1'b1);
   end

   // ---------------- ack driver (consumer) ----------------
   int ack_mode  = 0;   // 0 none, 1 fixed delay, 2 random
   int ack_delay = 0;
   int ack_cnt   = 0;
   bit ack_force = 0;
   bit ack_gen   = 0;

   always @(posedge clk) begin
      #1;
      if (request_trig === 1'b1) begin
         case (ack_mode)
            1: ack_cnt = ack_delay;
            2: ack_cnt = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
            default: ack_cnt = 0;
         endcase
      end
      ack_gen = 0;
      if (ack_cnt > 0) begin
         ack_cnt--;
         ack_gen = (ack_cnt == 0);
      end
      ack = ack_gen | ack_force;
      if (ack) ack_q.push_back(m_cyc + 1);
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_stats();
      pulses = 0; done_cnt = 0; err_edge = -1;
      trig_q.delete(); cnt_q.delete(); ack_q.delete();
   endtask

   task automatic wait_done(input int max_cyc, input string name);
      int n = 0;
      int start = done_cnt;
      while (done_cnt == start && n < max_cyc) begin
         tick();
         n++;
      end
      check({name, "_done_wait"}, (done_cnt != start), 1);
   endtask

   task automatic wait_pulses(input int target, input int max_cyc, input string name);
      int n = 0;
      while (pulses < target && n < max_cyc) begin
         tick();
         n++;
      end
      check({name, "_pulse_wait"}, (pulses >= target), 1);
   endtask

   task automatic pulse_clr();
      clr_err = 1; tick(); clr_err = 0; tick();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst = 0;
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_trig_count", trig_count, 0);
      check("rst_req_index", req_index, 0);
      check("rst_timeout_err", timeout_err, 0);
      rst = 1;
      repeat (2) tick();
      check("idle_busy", busy, 0);

      // Three requests, period 4, ack two cycles after each pulse.
      clear_stats();
      ack_mode = 1; ack_delay = 2; n_req = 3; period = 4; enable = 1;
      wait_done(200, "basic");
      enable = 0;
      repeat (5) tick();
      check("basic_pulses", pulses, 3);
      check("basic_done", done_cnt, 1);
      check("basic_count", trig_count, 3);
      check("basic_busy", busy, 0);
      check("basic_gap0", trig_q[1] - ack_q[0], 5);
      check("basic_gap1", trig_q[2] - ack_q[1], 5);

      // Two requests, never acked.
      clear_stats();
      ack_mode = 0; n_req = 2; period = 1; enable = 1;
      wait_done(200, "tmo");
      enable = 0;
      repeat (3) tick();
      check("tmo_pulses", pulses, 2);
      check("tmo_err", timeout_err, 1);
      check("tmo_err_delay", err_edge - trig_q[0], TO);
      check("tmo_second_pulse", trig_q[1] - trig_q[0], TO + 2);
      pulse_clr();
      check("tmo_clr", timeout_err, 0);

      // Enable dropped while request 0 of 4 waits for ack.
      clear_stats();
      ack_mode = 1; ack_delay = 3; n_req = 4; period = 2; enable = 1;
      wait_pulses(1, 50, "stop");
      enable = 0;
      repeat (30) tick();
      check("stop_pulses", pulses, 1);
      check("stop_done", done_cnt, 0);
      check("stop_busy", busy, 0);
      check("stop_index", req_index, 0);

      // Ack only during the REQ cycle is ignored; request times out.
      clear_stats();
      ack_mode = 0; n_req = 1; period = 0; enable = 1; ack_force = 1;
      tick();
      ack_force = 0;
      wait_done(100, "reqack");
      enable = 0;
      repeat (3) tick();
      check("reqack_pulses", pulses, 1);
      check("reqack_err", timeout_err, 1);
      check("reqack_err_delay", err_edge - trig_q[0], TO);
      pulse_clr();

      // n_req = 0 with enable never starts.
      clear_stats();
      n_req = 0; enable = 1;
      repeat (20) tick();
      check("nreq0_pulses", pulses, 0);
      check("nreq0_busy", busy, 0);
      enable = 0;

      // trig_count wrap: run up to 254, then two more.
      clear_stats();
      ack_mode = 1; ack_delay = 1; period = 0;
      n_req = CW'(254 - int'(m_count)); enable = 1;
      wait_done(3000, "wrap_fill");
      enable = 0;
      repeat (3) tick();
      check("wrap_254", trig_count, 254);
      clear_stats();
      n_req = 2; enable = 1;
      wait_done(100, "wrap");
      enable = 0;
      repeat (3) tick();
      check("wrap_255", cnt_q[0], 255);
      check("wrap_0", cnt_q[1], 0);

      // Reset in the middle of a gap.
      clear_stats();
      ack_mode = 1; ack_delay = 1; n_req = 3; period = 10; enable = 1;
      wait_pulses(1, 20, "gaprst");
      repeat (4) tick();
      rst = 0; enable = 0;
      tick();
      check("gaprst_busy", busy, 0);
      check("gaprst_trig", request_trig, 0);
      check("gaprst_count", trig_count, 0);
      check("gaprst_index", req_index, 0);
      check("gaprst_done", cycle_done, 0);
      rst = 1;
      clear_stats();
      repeat (20) tick();
      check("gaprst_quiet", pulses, 0);
      n_req = 1; enable = 1;
      wait_pulses(1, 20, "gaprst_re");
      enable = 0;
      repeat (3) tick();
      check("gaprst_recount", cnt_q[0], 1);

      // Randomized traffic.
      ack_mode = 2;
      n_req = 3; period = 2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) enable = 0;
         else if ($urandom_range(0, 14) == 0) enable = 1;
         if ($urandom_range(0, 9) == 0) n_req = CW'($urandom_range(0, 4));
         if ($urandom_range(0, 9) == 0) period = PW'($urandom_range(0, 5));
         clr_err   = ($urandom_range(0, 29) == 0);
         ack_force = ($urandom_range(0, 24) == 0);
         rst       = ($urandom_range(0, 599) != 0);
         tick();
      end
      enable = 0; ack_force = 0; clr_err = 0; rst = 1; ack_mode = 0;
      repeat (60) tick();
      check("exp_q_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
